// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t      - receiver FSM state encoding (legacy-compatible constants)
//   baud_cnt_width  - width of the baud down-counter for a given half-bit period
//   bit_idx_width   - width of the data-bit index for a given payload size
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t IDLE      = 3'd0;
  localparam rx_state_t START     = 3'd1;
  localparam rx_state_t DATA      = 3'd2;
  localparam rx_state_t PARITY    = 3'd3;
  localparam rx_state_t STOP      = 3'd4;
  localparam rx_state_t WAIT_IDLE = 3'd5;

  // The counter must hold a full bit period minus one (2*half - 1).
  function automatic int unsigned baud_cnt_width(input int unsigned clk_per_half_bit);
    return $clog2(2 * clk_per_half_bit);
  endfunction

  function automatic int unsigned bit_idx_width(input int unsigned data_bits);
    return $clog2(data_bits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rstn        - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata      - write request and data
//   push_ok          - write accepted this cycle (not full, or full with a pop)
//   pop              - read request; ignored while empty
//   rdata, rvalid    - head entry and non-empty flag
//   count            - occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     push_ok,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && ((count_q < FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign push_ok = do_push;
  assign rdata   = mem_q[rptr_q];
  assign rvalid  = (count_q != '0);
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a built-in receive FIFO.
//   clk, rstn   - clock, synchronous active-low reset
//   rxd         - asynchronous serial input, idles high
//   rdata       - FIFO head, valid while rvalid is high
//   rvalid      - FIFO not empty
//   rready      - consumer accepts rdata; pop on rvalid && rready
//   count       - FIFO occupancy, 0..DEPTH
//   ferr        - one-cycle pulse: bad stop bit
//   perr        - one-cycle pulse: parity mismatch (constant 0 without parity)
//   overrun     - one-cycle pulse: good frame dropped because the FIFO was full
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data
// bits; PARITY_ODD then selects odd (1) or even (0) parity.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned PARITY_ODD       = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rxd,
  output logic [DATA_BITS-1:0]   rdata,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ferr,
  output logic                   perr,
  output logic                   overrun
);

  localparam int unsigned CNT_W = baud_cnt_width(CLK_PER_HALF_BIT);
  localparam int unsigned BIT_W = bit_idx_width(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  if (CLK_PER_HALF_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_fifo: unsupported parameter set");
  end

  // Input synchroniser; resets to the idle level so reset release is quiet.
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

  assign rxs = sync_q[1];

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q;
  logic                 baud_tick;
  logic                 push, push_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  assign baud_tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (!baud_tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          // Line went back high before mid start bit: a glitch, not a frame.
          state_d = IDLE;
        end else begin
          cnt_d   = FULL_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!baud_tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // LSB arrives first, so shift in from the top.
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          cnt_d   = FULL_RELOAD;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!baud_tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bad_d = (((^shreg_q) ^ rxs) != PARITY_ODD[0]);
          cnt_d     = FULL_RELOAD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!baud_tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs) begin
          // Framing error wins over parity; wait out any break condition.
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
`ifdef UART_RX_PARITY_EN
        else if (par_bad_q) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      ferr_q    <= ferr_d;
      overrun_q <= push && !push_ok;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign ferr    = ferr_q;
  assign overrun = overrun_q;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (push),
    .wdata  (shreg_q),
    .push_ok(push_ok),
    .pop    (rready),
    .rdata  (rdata),
    .rvalid (rvalid),
    .count  (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// A queue-based reference model decides each frame's fate from the line-level
// rules (stop bit, parity, FIFO capacity); a monitor checks every handshake.
// The half-bit period is scaled down from the 115200-baud default to keep the
// run short; receiver timing scales linearly with it.
module tb_uart_rx_fifo;

  localparam int unsigned HALF       = 16;
  localparam int unsigned BIT_CYC    = 2 * HALF;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PARITY_ODD = 0;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       rxd    = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] count;
  logic       ferr, perr, overrun;

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(HALF),
    .DATA_BITS       (DATA_BITS),
    .DEPTH           (DEPTH),
    .PARITY_ODD      (PARITY_ODD)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rxd    (rxd),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .count  (count),
    .ferr   (ferr),
    .perr   (perr),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_perr = 0, exp_overrun = 0;
  int seen_ferr = 0, seen_perr = 0, seen_overrun = 0;
  int max_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: count error pulses and score every accepted word.
  always @(negedge clk) begin
    if (rstn) begin
      if (ferr)    seen_ferr++;
      if (perr)    seen_perr++;
      if (overrun) seen_overrun++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (rvalid && rready) begin : mon_pop
        logic [7:0] e;
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'b0, rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", {24'b0, rdata}, {24'b0, e});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PARITY_ODD[0];
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    logic par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (((^data) ^ par_bit) == PARITY_ODD[0]);
`endif
    rxd = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      tick(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_bit;
    tick(BIT_CYC);
`endif
    rxd = stop_bit;
    // Frame outcome is settled before the receiver samples the stop bit.
    if (!stop_bit)                 exp_ferr++;
    else if (!par_ok)              exp_perr++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else                           exp_overrun++;
    tick(BIT_CYC);
    rxd = 1'b1;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_ferr"},    seen_ferr,    exp_ferr);
    check({tag, "_perr"},    seen_perr,    exp_perr);
    check({tag, "_overrun"}, seen_overrun, exp_overrun);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20 * DEPTH) begin
      rready = 1'($urandom_range(0, 1));
      tick(1);
      guard++;
    end
    rready = 1'b0;
    tick(2);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_count"}, {29'b0, count}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         n;
    logic       bad;

    rstn = 1'b0;
    tick(4);
    check("rst_count",   {29'b0, count}, 0);
    check("rst_rvalid",  {31'b0, rvalid}, 0);
    check("rst_ferr",    {31'b0, ferr}, 0);
    check("rst_perr",    {31'b0, perr}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    rstn = 1'b1;
    tick(4);

    // Streaming with a ready consumer.
    max_cnt = 0;
    rready  = 1'b1;
    send_frame(8'h55, 1'b1, good_par(8'h55));
    tick(4);
    send_frame(8'hA3, 1'b1, good_par(8'hA3));
    tick(BIT_CYC);
    check("t1_drained", exp_q.size(), 0);
    check("t1_max_count", max_cnt, 1);
    check("t1_count", {29'b0, count}, 0);
    check_errs("t1");

    // Fill past capacity with a stalled consumer.
    rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, good_par(d));
      tick(4);
    end
    check("t2_count", {29'b0, count}, DEPTH);
    check("t2_model", exp_q.size(), DEPTH);
    check_errs("t2");
    drain("t2");

    // Break condition: twelve bit periods low.
    rxd = 1'b0;
    exp_ferr++;
    tick(12 * BIT_CYC);
    check("t3_count", {29'b0, count}, 0);
    check_errs("t3");
    rxd = 1'b1;
    tick(BIT_CYC);
    rready = 1'b1;
    send_frame(8'h7E, 1'b1, good_par(8'h7E));
    tick(4);
    check("t3_drained", exp_q.size(), 0);
    check_errs("t3b");

    // Short low glitch: a false start only.
    rready = 1'b0;
    rxd    = 1'b0;
    tick(10);
    rxd = 1'b1;
    tick(4 * BIT_CYC);
    check("t4_count", {29'b0, count}, 0);
    check_errs("t4");
    rready = 1'b1;
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    tick(4);
    check("t4_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    rready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(4);
    check("t5_good_count", {29'b0, count}, 1);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(4);
    check("t5_bad_count", {29'b0, count}, 1);
    check_errs("t5");
    drain("t5");
`endif

    // Reset mid-frame with two words buffered.
    rready = 1'b0;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    tick(4);
    send_frame(8'h22, 1'b1, good_par(8'h22));
    tick(4);
    check("t6_pre_count", {29'b0, count}, 2);
    rxd = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'(i & 1);
      tick(BIT_CYC);
    end
    rstn = 1'b0;
    rxd  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_count",  {29'b0, count}, 0);
    check("t6_rst_rvalid", {31'b0, rvalid}, 0);
    rstn = 1'b1;
    exp_q.delete();
    tick(3 * BIT_CYC);
    rready = 1'b1;
    send_frame(8'hC4, 1'b1, good_par(8'hC4));
    tick(4);
    check("t6_drained", exp_q.size(), 0);
    check_errs("t6");

    // Random bursts with occasional framing errors, then random-paced drain.
    for (int b = 0; b < 6; b++) begin
      rready = 1'b0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        send_frame(d, !bad, good_par(d));
        tick($urandom_range(4, BIT_CYC));
      end
      tick(4);
      check("rnd_count", {29'b0, count}, exp_q.size());
      check_errs("rnd");
      drain("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
